// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Latency: n/a (constants only); backpressure: none.
package seg7_pkg;

  typedef logic [3:0] digit_t;

  // Lit-high patterns {g,f,e,d,c,b,a}; entry 15 sits in the top slice
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to lit-high seven-segment pattern.
// Latency: combinational; backpressure: none.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  digit_t      nib_i,
  output logic [6:0]  seg_o
);

  assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver; frame-synchronous value updates, optional SEG7_LZB_EN blanking.
// Latency: 1 cycle from index/display/blank to pins; backpressure: none, load is a strobe.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_PIN_OFF = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] AN_PIN_OFF = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, disp_q, disp_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
  logic                    pending_q, pending_d;
  logic [6:0]              seg_q, seg_d;
  logic                    seg_dp_q, seg_dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q;

  logic                    tick, boundary;
  digit_t                  cur_nib;
  logic                    cur_dp, cur_lz, digit_off;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic [6:0]              dec_seg, seg_lit;
  logic                    dp_lit;
  logic [NUM_DIGITS-1:0]   an_lit;

  assign tick     = (cnt_q == CNT_LAST);
  assign boundary = tick && (idx_q == IDX_LAST);

`ifdef SEG7_LZB_EN
  logic lz_run;
  // A digit is blanked only if it and every digit above it is an undotted zero
  always_comb begin
    lead_zero = '0;
    lz_run    = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run       = lz_run && (disp_q[4*i +: 4] == 4'h0) && !disp_dp_q[i];
      lead_zero[i] = lz_run;
    end
    lead_zero[0] = 1'b0;
  end
`else
  assign lead_zero = '0;
`endif

  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib = disp_q[4*i +: 4];
        cur_dp  = disp_dp_q[i];
        cur_lz  = lead_zero[i];
      end
    end
  end

  seg7_hex_decode u_dec (
    .nib_i (cur_nib),
    .seg_o (dec_seg)
  );

  // Blanked digits keep their anode pulse so scan timing never changes
  always_comb begin
    digit_off = blank | cur_lz;
    seg_lit   = digit_off ? SEG_OFF : dec_seg;
    dp_lit    = ~digit_off & cur_dp;
    an_lit    = blank ? '0 : (NUM_DIGITS'(1) << idx_q);
    seg_d     = ACTIVE_LOW ? ~seg_lit : seg_lit;
    seg_dp_d  = ACTIVE_LOW ? ~dp_lit  : dp_lit;
    an_d      = ACTIVE_LOW ? ~an_lit  : an_lit;
  end

  always_comb begin
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    pending_d   = pending_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    if (load) begin
      shadow_d    = value;
      shadow_dp_d = dp_in;
      pending_d   = 1'b1;
    end
    // A load coinciding with the boundary bypasses the shadow
    if (boundary) begin
      if (load) begin
        disp_d    = value;
        disp_dp_d = dp_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        disp_dp_d = shadow_dp_q;
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_PIN_OFF;
      seg_dp_q     <= ACTIVE_LOW;
      an_q         <= AN_PIN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      an_q         <= an_d;
      frame_done_q <= boundary;
    end
  end

  assign seg        = seg_q;
  assign seg_dp     = seg_dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a frame-arithmetic reference model predicts the pins
// for every clock edge, and a separate monitor compares them one cycle later.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int FRAME = N * SD;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load = 1'b0;
  logic [4*N-1:0]    value = '0;
  logic [N-1:0]      dp_in = '0;
  logic              blank = 1'b0;
  logic [6:0]        seg;
  logic              seg_dp;
  logic [N-1:0]      an;
  logic              frame_done;

  seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .ACTIVE_LOW(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .blank      (blank),
    .seg        (seg),
    .seg_dp     (seg_dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]   seg;
    logic         dp;
    logic [N-1:0] an;
    logic         fd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: p = clock edges since reset release
  int           p = 0;
  logic [15:0]  m_disp = '0, m_shadow = '0;
  logic [3:0]   m_disp_dp = '0, m_shadow_dp = '0;
  bit           m_pend = 0;

  function automatic logic [6:0] lit_pattern(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h67;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit ld, input logic [15:0] v,
                            input logic [3:0] d, input bit bl);
    exp_t e;
    int   dig;
    bit   bnd, lz;
    logic [6:0] lit;
    logic dpl;
    if (r) begin
      e.seg = 7'h7F; e.dp = 1'b1; e.an = '1; e.fd = 1'b0;
      p = 0; m_disp = '0; m_shadow = '0; m_disp_dp = '0; m_shadow_dp = '0; m_pend = 0;
    end else begin
      dig = (p / SD) % N;
      bnd = (p % FRAME) == FRAME - 1;
`ifdef SEG7_LZB_EN
      lz = (dig > 0) && ((m_disp >> (4 * dig)) == 16'h0) && ((m_disp_dp >> dig) == 4'h0);
`else
      lz = 0;
`endif
      lit = lit_pattern(4'((m_disp >> (4 * dig)) & 16'hF));
      dpl = m_disp_dp[dig];
      if (bl || lz) begin
        lit = 7'h00;
        dpl = 1'b0;
      end
      e.seg = ~lit;
      e.dp  = ~dpl;
      e.an  = bl ? 4'hF : ~(4'b0001 << dig);
      e.fd  = bnd;
      if (bnd && ld) begin
        m_disp = v; m_disp_dp = d; m_pend = 0;
      end else if (bnd && m_pend) begin
        m_disp = m_shadow; m_disp_dp = m_shadow_dp; m_pend = 0;
      end
      if (ld) begin
        m_shadow = v; m_shadow_dp = d;
        if (!bnd) m_pend = 1;
      end
      p++;
    end
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit r, input bit ld, input logic [15:0] v,
                       input logic [3:0] d, input bit bl);
    @(negedge clk);
    rst = r; load = ld; value = v; dp_in = d; blank = bl;
    model_step(r, ld, v, d, bl);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 16'h0, 4'h0, 0);
  endtask

  task automatic to_boundary();
    for (int k = 0; k < FRAME && (p % FRAME) != FRAME - 1; k++) idle(1);
  endtask

  task automatic to_frame_start();
    for (int k = 0; k < FRAME && (p % FRAME) != 0; k++) idle(1);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: pins are compared one step after the edge that produced them
  exp_t mon_e;
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("seg",        32'(seg),        32'(mon_e.seg));
      chk("seg_dp",     32'(seg_dp),     32'(mon_e.dp));
      chk("an",         32'(an),         32'(mon_e.an));
      chk("frame_done", 32'(frame_done), 32'(mon_e.fd));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    bit          r, ld, bl;
    logic [15:0] v;
    logic [3:0]  d;

    for (int k = 0; k < 3; k++) cycle(1, 0, 16'h0, 4'h0, 0);
    idle(40);

    idle(5);
    cycle(0, 1, 16'h12AF, 4'h0, 0);
    idle(40);

    to_frame_start();
    cycle(0, 1, 16'h0001, 4'h0, 0);
    idle(2);
    cycle(0, 1, 16'h0002, 4'h0, 0);
    idle(40);

    to_boundary();
    cycle(0, 1, 16'hBEEF, 4'h0, 0);
    idle(40);

    idle(3);
    for (int k = 0; k < 3; k++) cycle(0, 0, 16'h0, 4'h0, 1);
    idle(20);

    cycle(0, 1, 16'h0050, 4'h0, 0);
    idle(40);
    cycle(0, 1, 16'h0300, 4'h4, 0);
    idle(40);

    idle(6);
    cycle(0, 1, 16'h9876, 4'hA, 0);
    cycle(1, 0, 16'h0, 4'h0, 0);
    idle(40);

    for (int c = 0; c < 2500; c++) begin
      r  = ($urandom_range(0, 599) == 0);
      ld = ($urandom_range(0, 7) == 0);
      v  = 16'($urandom);
      if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(1, 4));
      d  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      bl = ($urandom_range(0, 15) == 0);
      cycle(r, ld, v, d, bl);
    end
    idle(2);

    @(posedge clk);
    #2;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed driver for a row of common-anode seven-segment digits. It takes a packed hexadecimal value, decodes one digit at a time and scans the digit enables at a programmable rate. New values are applied only at frame boundaries, so the display never tears. It sits between datapath blocks (ADC result, counters) and the board's shared segment/anode pins.

## Interface

- `NUM_DIGITS`, default 4: number of digits scanned, ≥1.
- `SCAN_DIV`, default 50000: clocks each digit stays lit, ≥1.
- `ACTIVE_LOW`, default 1: 1 means segment/anode pins are driven 0 to light; 0 inverts all pin polarities.

Ports:

- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: single-cycle strobe; captures `value`/`dp_in`.
- `value` in 4·NUM_DIGITS: hex nibbles; nibble 0 is the rightmost digit.
- `dp_in` in NUM_DIGITS: decimal-point request per digit.
- `blank` in 1: forces all segments and anodes off while high.
- `seg` out 7: segments {g,f,e,d,c,b,a}, registered.
- `seg_dp` out 1: decimal-point segment, registered.
- `an` out NUM_DIGITS: one-hot digit enable, registered.
- `frame_done` out 1: one-cycle pulse when the last digit's slot ends.

## Operation

- Prescaler `cnt` counts 0..SCAN_DIV-1. `tick` = (`cnt` == SCAN_DIV-1), after which `cnt` returns to 0.
- Digit index `idx` advances on `tick`, wrapping NUM_DIGITS-1 → 0.
- Frame boundary = `tick` && `idx` == NUM_DIGITS-1. `frame_done` is registered and goes high in the cycle after the boundary.
- `load` = 1: `value` and `dp_in` go into the shadow register and `pending` is set.
- At a frame boundary with `pending` = 1: the display register takes the shadow and `pending` clears.
- Simultaneous `load` and frame boundary: the display register takes the incoming `value`/`dp_in` directly, and `pending` clears.
- `load` with no intervening boundary: the last load wins.
- Decode table, lit-high form {g..a}:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:67, A:77, b:7C, C:39, d:5E, E:79, F:71
- With ACTIVE_LOW = 1, these values are inverted at the pins (0 → 1000000).
- `blank` = 1: on the next cycle, all pins go to the off level. Scanning and loading continue unaffected.

## Timing

- Reset values:
  - `cnt` = 0, `idx` = 0, shadow = 0, display = 0, `pending` = 0.
  - `seg` / `seg_dp` / `an` = off level (all 1s when ACTIVE_LOW).
  - `frame_done` = 0.
- Output latency: 1 cycle from `idx`/display/`blank` to the pins. The first cycle after reset release drives digit 0.
- Load-to-pin latency: at most one frame plus one cycle, i.e. NUM_DIGITS·SCAN_DIV+1 cycles.
- SCAN_DIV = 1: `tick` is asserted every cycle.
- NUM_DIGITS = 1: every `tick` is a frame boundary.
- Reset during a scan: the next cycle restores all reset values. A pending load is discarded.

## Configuration

- `SEG7_LZB_EN` defined (leading-zero blanking):
  - A digit above index 0 is forced off when it and all higher digits are 0 and have `dp_in` = 0.
  - Digit 0 is never blanked.
  - Its anode is still pulsed in its slot, so scan timing is unchanged.
- `SEG7_LZB_EN` undefined: every digit always shows its nibble.

## Structure

- `seg7_pkg` holds:
  - the 16-entry lit-high segment table constant;
  - the `SEG_OFF` constant;
  - a `digit_t` typedef for the 4-bit nibble.
- Sub-module `seg7_hex_decode`: combinational nibble → 7-bit lit-high pattern, driven from the table in `seg7_pkg`.
- The top level owns the prescaler, index, shadow/display registers, blanking and the polarity inversion.

## Test plan

All scenarios use NUM_DIGITS = 4, SCAN_DIV = 4, ACTIVE_LOW = 1.

1. Reset, then release: `seg` = 7F, `an` = 1111 in the reset cycle, then `an` = 1110. `an` steps 1101, 1011, 0111 every 4 cycles. `frame_done` pulses once every 16 cycles.
2. `load` value = 16'h12AF mid-frame: pins keep showing 0 until the boundary. The next frame shows digit 0 = 0001110 (F), digit 1 = 0001000 (A), digit 2 = 0100100, digit 3 = 1111001.
3. `load` 16'h0001 then `load` 16'h0002 within the same frame: only 0002 is ever displayed.
4. `load` asserted exactly on the boundary cycle with 16'hBEEF: the next frame displays BEEF, and `pending` = 0 afterwards.
5. `blank` high for 3 cycles: `seg`/`an` are all 1s one cycle later. `idx` progression and `frame_done` cadence are unchanged.
6. With `SEG7_LZB_EN`, display 16'h0050: digits 3 and 2 show 1111111, digit 1 = 0010010, digit 0 = 1000000. Without the macro, digits 3 and 2 show 1000000.
